// File: rtl/serial_pkg.sv
// Shared encodings for the serial w-stream transmitter and the detector family.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } tx_state_e;

    localparam logic DEF_IDLE_LVL = 1'b0;

endpackage

// File: rtl/serial_word_tx_piso.sv
// Parallel-in/serial-out register with load, shift enable and direction select.
// next_bit is the bit that will sit at the output end after this edge.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             shift_en,
    input  logic             msb_first,
    input  logic [WIDTH-1:0] d,
    output logic             next_bit
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (ld)
            q <= d;
        else if (shift_en)
            q <= msb_first ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
    end

    always_comb begin
        next_bit = 1'b0;
        if (ld)
            next_bit = msb_first ? d[WIDTH-1] : d[0];
        else if (shift_en)
            next_bit = msb_first ? q[WIDTH-2] : q[1];
    end

endmodule

// File: rtl/serial_word_tx.sv
// Word-to-serial transmitter: valid/ready load, WIDTH bits on w with w_en,
// programmable idle gap, and a one-cycle done pulse after the last bit.
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int GAP       = 2,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_LVL  = DEF_IDLE_LVL
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             w,
    output logic             w_en,
    output logic             busy,
    output logic             done
);

    localparam int              CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]   BIT_LD = CW'(WIDTH - 1);
    localparam logic [3:0]      GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    tx_state_e       state, nxt;
    logic [CW-1:0]   bit_cnt;
    logic [3:0]      gap_cnt;
    logic            hs, shift_en, last, next_bit;

    piso_shift #(.WIDTH(WIDTH)) u_piso (
        .clk       (Clock),
        .rst       (Reset),
        .ld        (hs),
        .shift_en  (shift_en),
        .msb_first (MSB_FIRST),
        .d         (data_in),
        .next_bit  (next_bit)
    );

    always_comb begin
        nxt      = state;
        hs       = 1'b0;
        shift_en = 1'b0;
        last     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    hs  = 1'b1;
                    nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == '0) begin
                    last = 1'b1;
                    nxt  = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 4'd0)
                    nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Outputs are loaded from the next state so every port comes straight off a flop.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            gap_cnt <= 4'd0;
            ready   <= 1'b1;
            w       <= IDLE_LVL;
            w_en    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= nxt;
            if (hs)
                bit_cnt <= BIT_LD;
            else if (shift_en && bit_cnt != '0)
                bit_cnt <= bit_cnt - 1'b1;
            if (last)
                gap_cnt <= GAP_LD;
            else if (state == ST_GAP && gap_cnt != 4'd0)
                gap_cnt <= gap_cnt - 1'b1;
            ready <= (nxt == ST_IDLE);
            busy  <= (nxt != ST_IDLE);
            w_en  <= (nxt == ST_SHIFT);
            w     <= (nxt == ST_SHIFT) ? next_bit : IDLE_LVL;
            done  <= last;
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench: MSB-first/GAP=2 and LSB-first/GAP=0 instances of serial_word_tx.
module tb_serial_word_tx;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] data_a = '0, data_b = '0;
    logic       load_a = 1'b0, load_b = 1'b0;
    logic       ready_a, w_a, w_en_a, busy_a, done_a;
    logic       ready_b, w_b, w_en_b, busy_b, done_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clock = ~Clock;

    serial_word_tx #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) u_msb (
        .Clock(Clock), .Reset(Reset), .data_in(data_a), .load(load_a),
        .ready(ready_a), .w(w_a), .w_en(w_en_a), .busy(busy_a), .done(done_a)
    );

    serial_word_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) u_lsb (
        .Clock(Clock), .Reset(Reset), .data_in(data_b), .load(load_b),
        .ready(ready_b), .w(w_b), .w_en(w_en_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    logic [7:0] seq;
    int         cnt;

    initial begin
        // reset: two cycles, then first cycle after release
        tick(); tick();
        Reset = 1'b0;
        tick();
        chk("rst_ready", ready_a, 1);
        chk("rst_busy",  busy_a,  0);
        chk("rst_w_en",  w_en_a,  0);
        chk("rst_w",     w_a,     0);
        chk("rst_done",  done_a,  0);
        chk("rst_ready_b", ready_b, 1);

        // MSB-first A5 with GAP=2
        data_a = 8'hA5; load_a = 1'b1;
        tick();
        load_a = 1'b0;
        chk("a5_ready_c1", ready_a, 0);
        seq = '0; cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            seq = {seq[6:0], w_a};
            if (w_en_a) cnt++;
            if (done_a) cnt += 100;
            tick();
        end
        chk("a5_bits", seq, 8'hA5);
        chk("a5_en_cnt", cnt, 8);
        chk("a5_done_c9", done_a, 1);
        chk("a5_w_en_c9", w_en_a, 0);
        chk("a5_busy_c9", busy_a, 1);
        tick();
        chk("a5_done_c10", done_a, 0);
        chk("a5_ready_c10", ready_a, 0);
        tick();
        chk("a5_ready_c11", ready_a, 1);
        chk("a5_busy_c11", busy_a, 0);

        // LSB-first back-to-back, GAP=0, load held
        data_b = 8'h01; load_b = 1'b1;
        tick();
        data_b = 8'h80;
        seq = '0; cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            seq = {seq[6:0], w_b};
            if (w_en_b) cnt++;
            tick();
        end
        chk("lsb01_bits", seq, 8'h80);
        chk("lsb01_en_cnt", cnt, 8);
        chk("lsb_done_c9", done_b, 1);
        chk("lsb_ready_c9", ready_b, 1);
        chk("lsb_w_en_c9", w_en_b, 0);
        tick();
        load_b = 1'b0;
        chk("lsb_w_en_c10", w_en_b, 1);
        seq = '0;
        for (int c = 10; c <= 17; c++) begin
            seq = {seq[6:0], w_b};
            tick();
        end
        chk("lsb80_bits", seq, 8'h01);
        chk("lsb80_done", done_b, 1);

        // ignored load during SHIFT
        data_a = 8'h00; load_a = 1'b1;
        tick();
        load_a = 1'b0;
        seq = '0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) begin data_a = 8'hFF; load_a = 1'b1; end
            if (c == 4) load_a = 1'b0;
            seq = {seq[6:0], w_a};
            tick();
        end
        chk("ign_bits", seq, 8'h00);
        cnt = 0;
        for (int c = 9; c <= 24; c++) begin
            if (w_en_a) cnt++;
            tick();
        end
        chk("ign_never_sent", cnt, 0);
        chk("ign_ready", ready_a, 1);

        // reset on the 4th bit of F0
        data_a = 8'hF0; load_a = 1'b1;
        tick();
        load_a = 1'b0;
        tick(); tick(); tick();
        chk("mid_w_en_c4", w_en_a, 1);
        chk("mid_w_c4", w_a, 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mid_w_en", w_en_a, 0);
        chk("mid_busy", busy_a, 0);
        chk("mid_ready", ready_a, 1);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_a) cnt++;
            tick();
        end
        chk("mid_no_done", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Transmit end of the serial `w` stream that the team's Moore sequence-detector FSMs consume.
- Accepts a parallel word through a valid/ready handshake and shifts it out one bit per clock on `w`, with a qualifying strobe `w_en`.
- Inserts a programmable idle gap between words and pulses `done` when each word completes.
- Used as the stimulus/driver side of detector blocks, in silicon and in benches.

Parameters:
- WIDTH, 8: bits per word, legal range 2..32.
- GAP, 2: idle cycles (`w_en`=0, `w`=IDLE_LVL) inserted after each word, legal range 0..15.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LVL, 0: value driven on `w` whenever `w_en`=0.

Ports:
- Clock  in  1  single system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  word to transmit; sampled only on handshake.
- load  in  1  valid: `data_in` is presented.
- ready  out  1  block can accept a word this cycle.
- w  out  1  serial data bit.
- w_en  out  1  `w` carries a data bit this cycle.
- busy  out  1  a word is in flight, including the gap.
- done  out  1  one-cycle pulse on the cycle after the last bit of a word.

Behaviour:
- Clock and reset
  - One clock, `Clock`. Reset is synchronous and active-high (`Reset`=1 sampled at a rising edge).
  - Reset has priority over all other inputs.
- Reset values: state=IDLE, shift register=0, bit counter=0, gap counter=0, ready=1, w=IDLE_LVL, w_en=0, busy=0, done=0.
- All outputs are registered.
- State machine has three states: IDLE, SHIFT, GAP.
- IDLE
  - ready=1, w_en=0, busy=0.
  - Handshake: `load`=1 at a rising edge while ready=1. On handshake, capture `data_in` into the shift register, load the bit counter with WIDTH-1, and go to SHIFT.
  - `load` while ready=0 is ignored. There is no queueing; the source must hold `load` until it sees ready.
- SHIFT
  - ready=0, busy=1, w_en=1.
  - `w` = shift register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0).
  - Each cycle, shift toward the output end, zero-fill, and decrement the counter.
  - When the counter reaches 0 (last bit on `w`), the next state is GAP if GAP>0, otherwise IDLE.
  - `done`=1 for exactly the cycle after the last bit.
- GAP
  - w_en=0, w=IDLE_LVL, busy=1, ready=0.
  - Lasts exactly GAP cycles, then go to IDLE.
- Latency
  - The first bit appears on `w` in the cycle after the handshake edge.
  - A word occupies WIDTH cycles of `w_en`, then GAP idle cycles.
  - Back-to-back throughput is one word per WIDTH+GAP+1 cycles; the +1 is the IDLE handshake cycle.
- `done` timing: the `done` pulse coincides with the first GAP cycle, or with the IDLE cycle when GAP=0.
  - With GAP=0, a new handshake can occur in that same cycle. `done` and the handshake are then simultaneous and both take effect.
- Reset mid-word (SHIFT or GAP)
  - The word is abandoned and no `done` is issued.
  - Outputs take their reset values at the next edge.
- `data_in` changes after the handshake have no effect on the word in flight.
- Counter widths: bit counter is $clog2(WIDTH) bits; gap counter is 4 bits. No wrap beyond the programmed limits.

Decomposition:
- Shared package `serial_pkg` holds:
  - the state encoding constants IDLE=2'b00, SHIFT=2'b01, GAP=2'b10;
  - the default IDLE_LVL.
- Illegal encoding 2'b11 recovers to IDLE with reset output values. The detector family uses the same package.
- One sub-module, `piso_shift`: a parameterised parallel-in/serial-out register with load, shift-enable and direction select.
- FSM and counters stay in the top module.

Test Plan:
- Reset behaviour: assert Reset for 2 cycles, then release → ready=1, busy=0, w_en=0, w=0, done=0 on the first cycle after release.
- Basic word, WIDTH=8, MSB_FIRST=1, GAP=2: load data_in=8'hA5 → `w` over the 8 `w_en` cycles is 1,0,1,0,0,1,0,1; done pulses once on cycle 9 after the handshake; ready returns to 1 on cycle 11.
- LSB-first and back-to-back, MSB_FIRST=0, GAP=0: load is held high with 8'h01 then 8'h80 → sequence is 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1; second handshake occurs on the done cycle; exactly 9 cycles between first bits.
- Ignored load: pulse load with 8'hFF while in SHIFT of 8'h00 → `w` stays all zeros; the 8'hFF word is never sent.
- Reset mid-word: assert Reset on the 4th bit of 8'hF0 → w_en=0, busy=0, ready=1 next cycle; no done pulse ever appears for that word.
- End-to-end with detector: drive the team's 6-state `w`-driven detector from `w`, gated by `w_en`, and apply a word chosen to steer it into state F → detector output p asserts on the expected cycle; same word with one bit flipped → p stays 0.
